// File: rtl/hack_decoder.sv
// Hack CPU instruction decoder: IDLE -> EXEC -> RESOLVE handshake with registered controls.
// Define HACK_DECODER_ILLEGAL_CHECK_EN to flag C-instructions whose bits [14:13] are not 2'b11.
module hack_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        zx,
    output logic        nx,
    output logic        zy,
    output logic        ny,
    output logic        f,
    output logic        no,
    output logic        a_sel,
    output logic        load_a,
    output logic        load_d,
    output logic        write_m,
    output logic        is_a_instr,
    output logic [15:0] a_value,
    output logic        ctrl_valid,
    input  logic        ctrl_ready,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic        jump_valid,
    output logic        jump,
    output logic        illegal
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResolve
    } state_e;

    typedef struct packed {
        logic        a_sel;
        logic [5:0]  alu;
        logic        load_a;
        logic        load_d;
        logic        write_m;
        logic        is_a;
        logic [15:0] a_value;
        logic [2:0]  jmp;
        logic        illegal;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    ctrl_t  dec;
    logic   jump_q, jump_d;
    logic   bad_enc;

`ifdef HACK_DECODER_ILLEGAL_CHECK_EN
    assign bad_enc = instr[15] & (instr[14:13] != 2'b11);
`else
    logic unused_enc_bits;
    assign unused_enc_bits = ^instr[14:13];
    assign bad_enc = 1'b0;
`endif

    always_comb begin
        dec = '0;
        if (!instr[15]) begin
            dec.is_a    = 1'b1;
            dec.load_a  = 1'b1;
            dec.a_value = {1'b0, instr[14:0]};
        end else begin
            dec.a_sel   = instr[12];
            dec.alu     = instr[11:6];
            dec.illegal = bad_enc;
            // Illegal encodings keep ALU bits but must not write anything or branch.
            if (!bad_enc) begin
                dec.load_a  = instr[5];
                dec.load_d  = instr[4];
                dec.write_m = instr[3];
                dec.jmp     = instr[2:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        jump_d  = jump_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    ctrl_d  = dec;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (ctrl_ready) begin
                    jump_d  = (ctrl_q.jmp[2] & alu_ng) |
                              (ctrl_q.jmp[1] & alu_zr) |
                              (ctrl_q.jmp[0] & ~alu_zr & ~alu_ng);
                    state_d = StResolve;
                end
            end
            StResolve: begin
                ctrl_d  = '0;
                jump_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                ctrl_d  = '0;
                jump_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            jump_q  <= jump_d;
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign ctrl_valid  = (state_q == StExec);
    assign jump_valid  = (state_q == StResolve);
    assign jump        = (state_q == StResolve) & jump_q;

    assign a_sel      = ctrl_q.a_sel;
    assign zx         = ctrl_q.alu[5];
    assign nx         = ctrl_q.alu[4];
    assign zy         = ctrl_q.alu[3];
    assign ny         = ctrl_q.alu[2];
    assign f          = ctrl_q.alu[1];
    assign no         = ctrl_q.alu[0];
    assign load_a     = ctrl_q.load_a;
    assign load_d     = ctrl_q.load_d;
    assign write_m    = ctrl_q.write_m;
    assign is_a_instr = ctrl_q.is_a;
    assign a_value    = ctrl_q.a_value;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_hack_decoder.sv
// Table-driven bench for hack_decoder with a scoreboard of expected control words.
module tb_hack_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        zx, nx, zy, ny, f, no, a_sel;
    logic        load_a, load_d, write_m, is_a_instr;
    logic [15:0] a_value;
    logic        ctrl_valid, ctrl_ready, alu_zr, alu_ng;
    logic        jump_valid, jump, illegal;

    always #5 clk = ~clk;

    hack_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .zx         (zx),
        .nx         (nx),
        .zy         (zy),
        .ny         (ny),
        .f          (f),
        .no         (no),
        .a_sel      (a_sel),
        .load_a     (load_a),
        .load_d     (load_d),
        .write_m    (write_m),
        .is_a_instr (is_a_instr),
        .a_value    (a_value),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .jump_valid (jump_valid),
        .jump       (jump),
        .illegal    (illegal)
    );

    // ctrl = {a_sel, zx, nx, zy, ny, f, no, load_a, load_d, write_m, is_a_instr}
    typedef struct packed {
        logic [10:0] ctrl;
        logic [15:0] a_value;
        logic        illegal;
        logic        jump;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        logic        zr;
        logic        ng;
        int          hold;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [10:0] ctrl_now();
        return {a_sel, zx, nx, zy, ny, f, no, load_a, load_d, write_m, is_a_instr};
    endfunction

    task automatic add(input logic [15:0] ins, input logic zr, input logic ng, input int hold,
                       input logic [10:0] ctrl, input logic [15:0] aval, input logic ill,
                       input logic jmp);
        vec_t v;
        v.ins  = ins;
        v.zr   = zr;
        v.ng   = ng;
        v.hold = hold;
        v.exp  = '{ctrl: ctrl, a_value: aval, illegal: ill, jump: jmp};
        vecs.push_back(v);
    endtask

    function automatic exp_t model(input logic [15:0] ins, input logic zr, input logic ng);
        exp_t e;
        logic bad;
        e = '0;
        if (!ins[15]) begin
            e.ctrl    = 11'b000_0000_1001;
            e.a_value = {1'b0, ins[14:0]};
        end else begin
`ifdef HACK_DECODER_ILLEGAL_CHECK_EN
            bad = (ins[14:13] != 2'b11);
`else
            bad = 1'b0;
`endif
            e.ctrl    = {ins[12], ins[11:6], (bad ? 3'b000 : ins[5:3]), 1'b0};
            e.illegal = bad;
            e.jump    = !bad && ((ins[2] && ng) || (ins[1] && zr) || (ins[0] && !zr && !ng));
        end
        return e;
    endfunction

    task automatic run(input vec_t v);
        exp_t got;
        int   budget;
        @(negedge clk);
        check("idle_instr_ready", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = v.ins;
        ctrl_ready  = 1'b0;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        budget = 0;
        while (!ctrl_valid && budget < 4) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("exec_next_cycle", budget, 0);
        check("exec_ctrl_valid", ctrl_valid, 1);
        got = sb.pop_front();
        check("exec_ctrl", ctrl_now(), got.ctrl);
        check("exec_a_value", a_value, got.a_value);
        check("exec_illegal", illegal, got.illegal);
        check("exec_instr_ready", instr_ready, 0);
        check("exec_jump_valid", jump_valid, 0);
        for (int h = 0; h < v.hold; h++) begin
            instr_valid = 1'b1;
            instr       = ~v.ins;
            @(posedge clk);
            #1;
            check("hold_ctrl", ctrl_now(), got.ctrl);
            check("hold_a_value", a_value, got.a_value);
            check("hold_ctrl_valid", ctrl_valid, 1);
            check("hold_instr_ready", instr_ready, 0);
            check("hold_jump_valid", jump_valid, 0);
        end
        instr_valid = 1'b0;
        ctrl_ready  = 1'b1;
        alu_zr      = v.zr;
        alu_ng      = v.ng;
        @(posedge clk);
        #1;
        ctrl_ready = 1'b0;
        alu_zr     = ~v.zr;
        alu_ng     = ~v.ng;
        check("resolve_jump_valid", jump_valid, 1);
        check("resolve_jump", jump, got.jump);
        check("resolve_ctrl_valid", ctrl_valid, 0);
        check("resolve_illegal", illegal, got.illegal);
        @(posedge clk);
        #1;
        check("after_jump_valid", jump_valid, 0);
        check("after_jump", jump, 0);
        check("after_instr_ready", instr_ready, 1);
        check("after_ctrl_valid", ctrl_valid, 0);
    endtask

    initial begin
        vec_t v;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        ctrl_ready  = 1'b0;
        alu_zr      = 1'b0;
        alu_ng      = 1'b0;

        add(16'h0015, 1'b1, 1'b1, 0, 11'b000_0000_1001, 16'h0015, 1'b0, 1'b0);
        add(16'hE7D0, 1'b0, 1'b0, 3, 11'b001_1111_0100, 16'h0000, 1'b0, 1'b0);
        add(16'hEA87, 1'b0, 1'b0, 0, 11'b010_1010_0000, 16'h0000, 1'b0, 1'b1);
        add(16'hE302, 1'b1, 1'b0, 0, 11'b000_1100_0000, 16'h0000, 1'b0, 1'b1);
        add(16'hE302, 1'b0, 1'b1, 0, 11'b000_1100_0000, 16'h0000, 1'b0, 1'b0);
        add(16'h7FFF, 1'b0, 1'b0, 0, 11'b000_0000_1001, 16'h7FFF, 1'b0, 1'b0);
        add(16'hFC38, 1'b0, 1'b0, 1, 11'b111_0000_1110, 16'h0000, 1'b0, 1'b0);
        add(16'hE301, 1'b0, 1'b0, 0, 11'b000_1100_0000, 16'h0000, 1'b0, 1'b1);
        add(16'hE304, 1'b0, 1'b1, 0, 11'b000_1100_0000, 16'h0000, 1'b0, 1'b1);
`ifdef HACK_DECODER_ILLEGAL_CHECK_EN
        add(16'hA03F, 1'b0, 1'b0, 0, 11'b000_0000_0000, 16'h0000, 1'b1, 1'b0);
`else
        add(16'hA03F, 1'b0, 1'b0, 0, 11'b000_0000_1110, 16'h0000, 1'b0, 1'b1);
`endif

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_instr_ready", instr_ready, 1);
        check("reset_ctrl_valid", ctrl_valid, 0);
        check("reset_jump_valid", jump_valid, 0);
        check("reset_jump", jump, 0);
        check("reset_illegal", illegal, 0);
        check("reset_ctrl", ctrl_now(), 0);
        check("reset_a_value", a_value, 0);

        foreach (vecs[i]) run(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            v.ins  = 16'($urandom);
            v.zr   = 1'($urandom);
            v.ng   = v.zr ? 1'b0 : 1'($urandom);
            v.hold = int'($urandom_range(0, 2));
            v.exp  = model(v.ins, v.zr, v.ng);
            run(v);
        end

        // Reset while stalled in EXEC discards the captured instruction.
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'h8000;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("rst_seq_ctrl_valid", ctrl_valid, 1);
        check("rst_seq_loads", {load_a, load_d, write_m}, 3'b000);
`ifdef HACK_DECODER_ILLEGAL_CHECK_EN
        check("rst_seq_illegal", illegal, 1);
`else
        check("rst_seq_illegal", illegal, 0);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        check("rst_mid_ctrl_valid", ctrl_valid, 0);
        check("rst_mid_instr_ready", instr_ready, 1);
        check("rst_mid_illegal", illegal, 0);
        check("rst_mid_ctrl", ctrl_now(), 0);
        check("rst_mid_a_value", a_value, 0);
        ctrl_ready = 1'b1;
        @(posedge clk);
        #1;
        ctrl_ready = 1'b0;
        check("rst_discard_jump_valid", jump_valid, 0);
        check("rst_discard_ctrl_valid", ctrl_valid, 0);
        check("rst_discard_instr_ready", instr_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hack_decoder.md
HACK_DECODER -- requirements
Module: hack_decoder

Interface
REQ-001 SHALL have one clock, clk (input, 1): all state updates on its rising edge.
REQ-002 SHALL have reset (input, 1): synchronous, active-high.
REQ-003 SHALL have instr_valid (input, 1): upstream offers instr.
REQ-004 SHALL have instr (input, 16): Hack instruction word.
REQ-005 SHALL have instr_ready (output, 1): block accepts instr this cycle.
REQ-006 SHALL have zx, nx, zy, ny, f, no (outputs, 1 each): registered ALU control bits.
REQ-007 SHALL have a_sel (output, 1): ALU y operand is M (1) or A (0).
REQ-008 SHALL have load_a, load_d, write_m (outputs, 1 each): destination enables.
REQ-009 SHALL have is_a_instr (output, 1) and a_value (output, 16): A-instruction flag and load value.
REQ-010 SHALL have ctrl_valid (output, 1) and ctrl_ready (input, 1): control-word handshake to the datapath.
REQ-011 SHALL have alu_zr, alu_ng (inputs, 1 each): ALU flags, valid in any cycle where ctrl_valid is 1.
REQ-012 SHALL have jump_valid (output, 1), jump (output, 1) and illegal (output, 1).

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESOLVE -> IDLE.
REQ-014 instr_ready SHALL be 1 only in IDLE, decoded from state only.
REQ-015 IDLE with instr_valid=1 SHALL capture instr and go to EXEC next cycle; instr_valid=0 stays in IDLE.
REQ-016 A-instruction (instr[15]=0): is_a_instr=1, a_value={1'b0,instr[14:0]}, load_a=1, load_d=0, write_m=0, a_sel=0, ALU bits 0, jump field 0.
REQ-017 C-instruction (instr[15]=1): a_sel=instr[12]; zx,nx,zy,ny,f,no=instr[11:6]; load_a=instr[5], load_d=instr[4], write_m=instr[3]; is_a_instr=0; a_value=0.
REQ-018 In EXEC, ctrl_valid SHALL be 1 and all control outputs SHALL hold constant until ctrl_ready=1.
REQ-019 EXEC with ctrl_ready=1 SHALL sample alu_zr/alu_ng that cycle, register jump = (instr[2]&ng)|(instr[1]&zr)|(instr[0]&~zr&~ng), and go to RESOLVE.
REQ-020 RESOLVE SHALL drive jump_valid=1 with the registered jump for exactly one cycle, ctrl_valid=0, then go to IDLE.
REQ-021 jump SHALL be 0 for A-instructions regardless of flags.
REQ-022 Outside RESOLVE, jump_valid and jump SHALL be 0; outside EXEC, ctrl_valid SHALL be 0.
REQ-023 Throughput SHALL be one instruction per 3 cycles with no backpressure; latency from accept to jump_valid SHALL be 2 cycles.
REQ-024 instr_valid SHALL be ignored outside IDLE; no instruction is buffered.

Reset
REQ-025 reset=1 SHALL force IDLE next edge from any state, including mid-EXEC with ctrl_ready=0.
REQ-026 After reset, ctrl_valid, jump_valid, jump, illegal and all control/destination outputs SHALL be 0, a_value=0x0000, instr_ready=1.
REQ-027 A captured but unresolved instruction SHALL be discarded on reset.

Configuration
REQ-028 Macro HACK_DECODER_ILLEGAL_CHECK_EN SHALL gate illegal-encoding detection.
REQ-029 With it defined: a C-instruction with instr[14:13]!=2'b11 SHALL set illegal=1 for its EXEC and RESOLVE cycles, forcing load_a, load_d, write_m and jump to 0; ALU bits still decoded.
REQ-030 Without it: instr[14:13] are ignored and illegal SHALL be tied to 0.

Verification
REQ-031 Accept 0x0015: EXEC shows is_a_instr=1, a_value=0x0015, load_a=1; RESOLVE shows jump_valid=1, jump=0.
REQ-032 Accept 0xE7D0 (D=D+1): zx=0, nx=1, zy=1, ny=1, f=1, no=1, load_d=1, load_a=0, write_m=0, a_sel=0.
REQ-033 Accept 0xEA87 (0;JMP) with zr=0, ng=0: jump_valid=1 and jump=1 two cycles after accept.
REQ-034 Accept 0xE302 (D;JEQ): zr=1 gives jump=1; zr=0, ng=1 gives jump=0.
REQ-035 Hold ctrl_ready=0 for 3 cycles in EXEC: outputs stable, instr_ready=0, no jump_valid; release gives jump_valid next cycle.
REQ-036 Assert reset during EXEC: next cycle IDLE, ctrl_valid=0, instr_ready=1; with macro defined, 0x8000 gives illegal=1 and all loads 0.
